// File: rtl/snr_event_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : snr_event_detector
// Purpose  : Turns the per-sample snr_db / signal_rms stream from the SNR
//            calculator into discrete acoustic events (claps, beats).
//            An event is confirmed after MIN_ON_SAMPLES consecutive samples
//            at or above ON_THRESH_DB, lasts until a sample falls below
//            OFF_THRESH_DB, and is followed by HOLDOFF_SAMPLES ignored
//            samples. Each event is reported as one record (peak RMS,
//            duration) on a single-entry valid/ready output slot.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   single clock, rising edge
//   reset          in   asynchronous, active-low reset
//   snr_db         in   SNR sample (unsigned dB)
//   signal_rms     in   RMS value paired with snr_db
//   snr_valid      in   input sample present
//   snr_ready      out  sample accepted (low only while in reset)
//   event_valid    out  event record held in the output slot
//   event_ready    in   consumer takes the record
//   event_peak_rms out  max signal_rms over the event
//   event_duration out  samples in the event (saturating)
//   event_count    out  total events detected, including dropped ones
//   event_overflow out  sticky: a record was dropped, slot was full
//   detect_active  out  high while an event is in progress
// ============================================================================
module snr_event_detector #(
  parameter int SNR_WIDTH       = 16,
  parameter int DATA_WIDTH      = 16,
  parameter int ON_THRESH_DB    = 12,
  parameter int OFF_THRESH_DB   = 6,
  parameter int MIN_ON_SAMPLES  = 4,
  parameter int HOLDOFF_SAMPLES = 2400,
  parameter int DUR_WIDTH       = 16,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SNR_WIDTH-1:0]   snr_db,
  input  logic [DATA_WIDTH-1:0]  signal_rms,
  input  logic                   snr_valid,
  output logic                   snr_ready,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [DATA_WIDTH-1:0]  event_peak_rms,
  output logic [DUR_WIDTH-1:0]   event_duration,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic                   event_overflow,
  output logic                   detect_active
);

  // Counter widths sized to hold their terminal values; at least one bit so
  // degenerate parameter choices (holdoff of 0, MIN_ON of 1) still elaborate.
  localparam int c_RUN_W  = (MIN_ON_SAMPLES  > 1) ? $clog2(MIN_ON_SAMPLES + 1)  : 1;
  localparam int c_HOLD_W = (HOLDOFF_SAMPLES > 1) ? $clog2(HOLDOFF_SAMPLES + 1) : 1;

  localparam logic [SNR_WIDTH-1:0] c_ON_THRESH  = SNR_WIDTH'(ON_THRESH_DB);
  localparam logic [SNR_WIDTH-1:0] c_OFF_THRESH = SNR_WIDTH'(OFF_THRESH_DB);
  localparam logic [c_RUN_W-1:0]   c_MIN_ON     = c_RUN_W'(MIN_ON_SAMPLES);
  localparam logic [c_HOLD_W-1:0]  c_HOLDOFF    = c_HOLD_W'(HOLDOFF_SAMPLES);
  localparam logic [DUR_WIDTH-1:0] c_DUR_ONE    = DUR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMING  = 2'd1,
    S_ACTIVE  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t                   r_state;
  logic [c_RUN_W-1:0]       r_run;
  logic [c_HOLD_W-1:0]      r_hold;
  logic [DATA_WIDTH-1:0]    r_peak;
  logic [DUR_WIDTH-1:0]     r_dur;

  logic                     r_event_valid;
  logic [DATA_WIDTH-1:0]    r_event_peak_rms;
  logic [DUR_WIDTH-1:0]     r_event_duration;
  logic [COUNT_WIDTH-1:0]   r_event_count;
  logic                     r_event_overflow;
  logic                     r_detect_active;

  logic                     w_accept;
  logic                     w_qual_on;
  logic                     w_qual_hold;
  logic                     w_slot_free;
  logic [c_RUN_W-1:0]       w_run_next;
  logic [c_HOLD_W-1:0]      w_hold_next;
  logic [DUR_WIDTH-1:0]     w_dur_inc;
  logic [DATA_WIDTH-1:0]    w_peak_max;

  // The block never back-pressures: ready simply follows the reset level,
  // so it is low exactly while reset is asserted.
  assign snr_ready   = reset;
  assign w_accept    = snr_valid && snr_ready;

  assign w_qual_on   = (snr_db >= c_ON_THRESH);
  assign w_qual_hold = (snr_db >= c_OFF_THRESH);

  // A new record may load if the slot is empty or is being drained this cycle.
  assign w_slot_free = !r_event_valid || event_ready;

  assign w_run_next  = r_run + 1'b1;
  assign w_hold_next = r_hold + 1'b1;
  assign w_dur_inc   = (&r_dur) ? r_dur : (r_dur + 1'b1);
  assign w_peak_max  = (signal_rms > r_peak) ? signal_rms : r_peak;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_run            <= '0;
      r_hold           <= '0;
      r_peak           <= '0;
      r_dur            <= '0;
      r_event_valid    <= 1'b0;
      r_event_peak_rms <= '0;
      r_event_duration <= '0;
      r_event_count    <= '0;
      r_event_overflow <= 1'b0;
      r_detect_active  <= 1'b0;
    end else begin
      // Consumer handshake; a record loaded below in the same cycle
      // overrides this clear.
      if (event_ready) begin
        r_event_valid <= 1'b0;
      end

      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (w_qual_on) begin
              r_peak <= signal_rms;
              r_dur  <= c_DUR_ONE;
              if (MIN_ON_SAMPLES == 1) begin
                r_state         <= S_ACTIVE;
                r_detect_active <= 1'b1;
              end else begin
                r_state <= S_ARMING;
                r_run   <= c_RUN_W'(1);
              end
            end
          end

          S_ARMING: begin
            if (w_qual_on) begin
              r_run  <= w_run_next;
              r_dur  <= w_dur_inc;
              r_peak <= w_peak_max;
              if (w_run_next == c_MIN_ON) begin
                r_state         <= S_ACTIVE;
                r_detect_active <= 1'b1;
              end
            end else begin
              // Too short to be an event: forget the partial measurement.
              r_state <= S_IDLE;
              r_run   <= '0;
              r_peak  <= '0;
              r_dur   <= '0;
            end
          end

          S_ACTIVE: begin
            if (w_qual_hold) begin
              r_dur  <= w_dur_inc;
              r_peak <= w_peak_max;
            end else begin
              // The releasing sample itself is not part of the event.
              r_event_count   <= r_event_count + 1'b1;
              r_detect_active <= 1'b0;
              r_run           <= '0;
              r_hold          <= '0;
              if (w_slot_free) begin
                r_event_valid    <= 1'b1;
                r_event_peak_rms <= r_peak;
                r_event_duration <= r_dur;
              end else begin
                r_event_overflow <= 1'b1;
              end
              if (HOLDOFF_SAMPLES == 0) begin
                r_state <= S_IDLE;
              end else begin
                r_state <= S_HOLDOFF;
              end
            end
          end

          S_HOLDOFF: begin
            // SNR is ignored here; only the sample count matters.
            r_hold <= w_hold_next;
            if (w_hold_next == c_HOLDOFF) begin
              r_state <= S_IDLE;
              r_hold  <= '0;
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign event_valid    = r_event_valid;
  assign event_peak_rms = r_event_peak_rms;
  assign event_duration = r_event_duration;
  assign event_count    = r_event_count;
  assign event_overflow = r_event_overflow;
  assign detect_active  = r_detect_active;

endmodule
`default_nettype wire

// File: tb/tb_snr_event_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_snr_event_detector
// Purpose  : Self-checking bench for snr_event_detector. Two instances share
//            the stimulus: one with a 16-bit duration and one with a 3-bit
//            duration to exercise saturation. A sample-level reference model
//            tracks the expected outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snr_event_detector;

  localparam int c_ON   = 12;
  localparam int c_OFF  = 6;
  localparam int c_MIN  = 4;
  localparam int c_HOLD = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] snr_db = '0;
  logic [15:0] signal_rms = '0;
  logic        snr_valid = 1'b0;
  logic        event_ready = 1'b0;

  logic        snr_ready, event_valid, event_overflow, detect_active;
  logic [15:0] event_peak_rms, event_duration, event_count;

  logic        s_snr_ready, s_event_valid, s_event_overflow, s_detect_active;
  logic [15:0] s_event_peak_rms, s_event_count;
  logic [2:0]  s_event_duration;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_run, m_peak, m_dur, m_hold_left;
  bit          m_in_event;
  bit          m_valid, m_ovf;
  int          m_s_peak, m_s_dur;
  logic [15:0] m_count;

  always #5 clk = ~clk;

  snr_event_detector #(
    .SNR_WIDTH(16), .DATA_WIDTH(16), .ON_THRESH_DB(c_ON), .OFF_THRESH_DB(c_OFF),
    .MIN_ON_SAMPLES(c_MIN), .HOLDOFF_SAMPLES(c_HOLD), .DUR_WIDTH(16), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .snr_db(snr_db), .signal_rms(signal_rms),
    .snr_valid(snr_valid), .snr_ready(snr_ready), .event_valid(event_valid),
    .event_ready(event_ready), .event_peak_rms(event_peak_rms),
    .event_duration(event_duration), .event_count(event_count),
    .event_overflow(event_overflow), .detect_active(detect_active)
  );

  snr_event_detector #(
    .SNR_WIDTH(16), .DATA_WIDTH(16), .ON_THRESH_DB(c_ON), .OFF_THRESH_DB(c_OFF),
    .MIN_ON_SAMPLES(c_MIN), .HOLDOFF_SAMPLES(c_HOLD), .DUR_WIDTH(3), .COUNT_WIDTH(16)
  ) dut_sat (
    .clk(clk), .reset(reset), .snr_db(snr_db), .signal_rms(signal_rms),
    .snr_valid(snr_valid), .snr_ready(s_snr_ready), .event_valid(s_event_valid),
    .event_ready(event_ready), .event_peak_rms(s_event_peak_rms),
    .event_duration(s_event_duration), .event_count(s_event_count),
    .event_overflow(s_event_overflow), .detect_active(s_detect_active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic m_reset();
    m_run = 0; m_peak = 0; m_dur = 0; m_hold_left = 0; m_in_event = 0;
    m_valid = 0; m_ovf = 0; m_s_peak = 0; m_s_dur = 0; m_count = '0;
  endtask

  // One clock edge of the reference: sample-level event rules, then the slot.
  task automatic m_edge(input bit v, input int snr, input int rms, input bit rdy);
    bit emit;
    emit = 0;
    if (v) begin
      if (m_hold_left > 0) begin
        m_hold_left--;
      end else if (m_in_event) begin
        if (snr < c_OFF) begin
          emit = 1;
          m_in_event = 0;
          m_hold_left = c_HOLD;
          m_count = m_count + 16'd1;
        end else begin
          m_dur++;
          if (rms > m_peak) m_peak = rms;
        end
      end else if (snr >= c_ON) begin
        if (m_run == 0) begin
          m_peak = rms;
          m_dur = 1;
        end else begin
          m_dur++;
          if (rms > m_peak) m_peak = rms;
        end
        m_run++;
        if (m_run >= c_MIN) begin
          m_in_event = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    if (emit) begin
      if (!m_valid || rdy) begin
        m_valid = 1;
        m_s_peak = m_peak;
        m_s_dur = m_dur;
      end else begin
        m_ovf = 1;
      end
    end else if (rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    check("snr_ready", {31'd0, snr_ready}, 32'd1);
    check("snr_ready_sat", {31'd0, s_snr_ready}, 32'd1);
    check("valid", {31'd0, event_valid}, {31'd0, m_valid});
    check("valid_sat", {31'd0, s_event_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("peak", {16'd0, event_peak_rms}, m_s_peak);
      check("peak_sat", {16'd0, s_event_peak_rms}, m_s_peak);
      check("dur", {16'd0, event_duration}, sat(m_s_dur, 16));
      check("dur_sat", {29'd0, s_event_duration}, sat(m_s_dur, 3));
    end
    check("count", {16'd0, event_count}, {16'd0, m_count});
    check("count_sat", {16'd0, s_event_count}, {16'd0, m_count});
    check("overflow", {31'd0, event_overflow}, {31'd0, m_ovf});
    check("overflow_sat", {31'd0, s_event_overflow}, {31'd0, m_ovf});
    check("active", {31'd0, detect_active}, {31'd0, m_in_event});
    check("active_sat", {31'd0, s_detect_active}, {31'd0, m_in_event});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_snr_ready"}, {31'd0, snr_ready}, 32'd0);
    check({tag, "_valid"}, {31'd0, event_valid}, 32'd0);
    check({tag, "_peak"}, {16'd0, event_peak_rms}, 32'd0);
    check({tag, "_dur"}, {16'd0, event_duration}, 32'd0);
    check({tag, "_count"}, {16'd0, event_count}, 32'd0);
    check({tag, "_overflow"}, {31'd0, event_overflow}, 32'd0);
    check({tag, "_active"}, {31'd0, detect_active}, 32'd0);
    check({tag, "_sat_valid"}, {31'd0, s_event_valid}, 32'd0);
    check({tag, "_sat_dur"}, {29'd0, s_event_duration}, 32'd0);
  endtask

  task automatic step(input bit v, input int snr, input int rms, input bit rdy);
    snr_valid   = v;
    snr_db      = snr[15:0];
    signal_rms  = rms[15:0];
    event_ready = rdy;
    @(posedge clk);
    m_edge(v, snr, rms, rdy);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    snr_valid = 1'b0;
    event_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    reset = 1'b1;
  endtask

  initial begin
    int rms_basic[8];
    rms_basic = '{100, 500, 900, 700, 300, 200, 1000, 50};

    // Quiet
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 3, 40, 1);
    check("quiet_count", {16'd0, event_count}, 32'd0);

    // Short burst
    for (int i = 0; i < 3; i++) step(1, 20, 900, 1);
    step(1, 3, 10, 1);
    for (int i = 0; i < 4; i++) step(1, 3, 10, 1);
    check("short_count", {16'd0, event_count}, 32'd0);

    // Basic event
    for (int i = 0; i < 8; i++) begin
      step(1, (i < 6) ? 20 : 8, rms_basic[i], 1);
      if (i == 2) check("basic_not_yet_active", {31'd0, detect_active}, 32'd0);
      if (i == 3) check("basic_active", {31'd0, detect_active}, 32'd1);
    end
    step(1, 3, 5000, 1);
    check("basic_valid", {31'd0, event_valid}, 32'd1);
    check("basic_peak", {16'd0, event_peak_rms}, 32'd1000);
    check("basic_dur", {16'd0, event_duration}, 32'd8);
    check("basic_dur_sat", {29'd0, s_event_duration}, 32'd7);
    check("basic_count", {16'd0, event_count}, 32'd1);
    check("basic_inactive", {31'd0, detect_active}, 32'd0);

    // Holdoff: 8 ignored samples, then a fresh event
    for (int i = 0; i < 5; i++) step(1, 20, 3000, 1);
    for (int i = 0; i < 3; i++) step(1, 3, 0, 1);
    check("holdoff_count", {16'd0, event_count}, 32'd1);
    for (int i = 0; i < 4; i++) step(1, 20, 77, 1);
    step(1, 3, 0, 1);
    check("holdoff_count2", {16'd0, event_count}, 32'd2);
    check("holdoff_dur2", {16'd0, event_duration}, 32'd4);

    // Back-pressure through two events, with a gap mid-event
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 20, 111, 0);
      step(0, 0, 9999, 0);
    end
    step(1, 3, 0, 0);
    for (int i = 0; i < c_HOLD; i++) step(1, 3, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 20, 222, 0);
    step(1, 3, 0, 0);
    check("bp_valid", {31'd0, event_valid}, 32'd1);
    check("bp_peak", {16'd0, event_peak_rms}, 32'd111);
    check("bp_dur", {16'd0, event_duration}, 32'd4);
    check("bp_count", {16'd0, event_count}, 32'd2);
    check("bp_overflow", {31'd0, event_overflow}, 32'd1);
    step(0, 0, 0, 1);
    check("bp_drain", {31'd0, event_valid}, 32'd0);
    check("bp_overflow_sticky", {31'd0, event_overflow}, 32'd1);

    // Reset during the 5th qualifying sample
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 20, 400, 1);
    check("mid_active", {31'd0, detect_active}, 32'd1);
    snr_valid = 1'b1; snr_db = 16'd20; signal_rms = 16'd400; event_ready = 1'b1;
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    check_zero("mid");
    @(posedge clk);
    #1;
    check_zero("mid_hold");
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step(1, 3, 400, 1);
    check("mid_after_count", {16'd0, event_count}, 32'd0);
    check("mid_after_valid", {31'd0, event_valid}, 32'd0);

    // Duration saturation
    for (int i = 1; i <= 10; i++) step(1, 20, i * 10, 1);
    step(1, 3, 0, 1);
    check("sat_dur16", {16'd0, event_duration}, 32'd10);
    check("sat_dur3", {29'd0, s_event_duration}, 32'd7);
    check("sat_peak", {16'd0, event_peak_rms}, 32'd100);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 24)),
           int'($urandom_range(0, 65535)), $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
